keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner. It is the successor to the fixed 4-row / 2-column keypad interface.
- Drives one active-low column at a time and samples active-low rows through a synchroniser.
- Debounces both press and release.
- Delivers each key code once over a valid/ready handshake to the display/consumer logic.
- Sits between the board keypad pins and the 7-segment/LED datapath on the 100 MHz clk domain.

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_sync.sv | 39 +++
 rtl/keypad_scanner.sv | 175 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and helpers for the matrix keypad scanner.
//   kp_state_t   : scanner FSM states
//   SYNC_STAGES  : depth of the row-input synchroniser
//   lowest_set() : index of the lowest set bit of an 8-bit vector (0 if none)
// -----------------------------------------------------------------------------
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      RELEASE  = 2'd3
   } kp_state_t;

   localparam int SYNC_STAGES = 2;

   // Priority encoder, lowest index wins. Walking from the top down lets the
   // last (lowest) set bit overwrite any higher one.
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_sync.sv
// -----------------------------------------------------------------------------
// keypad_sync
// Multi-flop synchroniser for asynchronous keypad rows. Every stage resets to
// all ones, matching idle (pulled-up, active-low) rows.
//   clk  in      system clock
//   rst  in      synchronous active-high reset
//   d    in  W   asynchronous input
//   q    out W   synchronised output (last stage)
// -----------------------------------------------------------------------------
module keypad_sync
   import keypad_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STAGES = SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: this flop array is a pipeline, not a RAM, so every entry is
         // reset; otherwise a stale low could appear as a key press after reset.
         for (int i = 0; i < STAGES; i++) stage[i] <= '1;
      end else begin
         // NOTE: non-blocking assignments make each stage take the previous
         // stage's old value; blocking here would collapse the chain to one flop.
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Parametrised matrix-keypad scanner. Drives one active-low column at a time,
// samples synchronised active-low rows once per column dwell, debounces press
// and release, and delivers each key code once over valid/ready.
//   clk        in           system clock
//   rst        in           synchronous active-high reset
//   row_n      in  ROWS     keypad rows, active low, asynchronous
//   col_n      out COLS     column drive, active low, at most one bit low
//   key_code   out CODE_W   accepted key, row*COLS + col
//   key_valid  out          key_code holds an unconsumed key
//   key_ready  in           consumer takes key_code when key_valid && key_ready
//   key_held   out          a debounced key is currently pressed
//   overrun    out          1-cycle pulse: new key dropped, previous unconsumed
// -----------------------------------------------------------------------------
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 3,
   parameter int CODE_W       = $clog2(ROWS*COLS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ROWS-1:0]   row_n,
   output logic [COLS-1:0]   col_n,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              key_held,
   output logic              overrun
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DIV_W = $clog2(SCAN_DIV);

   localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
   localparam logic [3:0]       DEB_TARGET = 4'(DEBOUNCE_CNT);

   logic [ROWS-1:0]  rows_s;
   logic             run;        // low in reset and the first edge after, keeps col_n idle
   logic [DIV_W-1:0] dwell;
   logic [COL_W-1:0] col_idx, col_nx, col_next;
   logic [ROW_W-1:0] row_lat, row_nx;
   logic [3:0]       deb_cnt, deb_nx;
   kp_state_t        state, state_nx;
   logic             sample, row_high, accept, release_done;

   keypad_sync #(
      .WIDTH (ROWS),
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (row_n),
      .q  (rows_s)
   );

   assign sample   = run && (dwell == DWELL_LAST);
   assign row_high = rows_s[row_lat];
   assign col_next = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;

   always_comb begin
      col_n = '1;
      if (run) col_n[col_idx] = 1'b0;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_nx     = state;
      deb_nx       = deb_cnt;
      col_nx       = col_idx;
      row_nx       = row_lat;
      accept       = 1'b0;
      release_done = 1'b0;
      case (state)
         SCAN: begin
            if (sample) begin
               if (&rows_s) begin
                  col_nx = col_next;
               end else begin
                  // Column stays where it is; it is the latched column.
                  row_nx = ROW_W'(lowest_set(8'(~rows_s)));
                  deb_nx = 4'd1;
                  if (DEB_TARGET == 4'd1) begin
                     state_nx = PRESSED;
                     accept   = 1'b1;
                  end else begin
                     state_nx = DEBOUNCE;
                  end
               end
            end
         end
         DEBOUNCE: begin
            if (sample) begin
               if (!row_high) begin
                  deb_nx = deb_cnt + 4'd1;
                  if (deb_cnt + 4'd1 == DEB_TARGET) begin
                     state_nx = PRESSED;
                     accept   = 1'b1;
                  end
               end else begin
                  state_nx = SCAN;
                  col_nx   = col_next;
               end
            end
         end
         PRESSED: begin
            state_nx = RELEASE;
            deb_nx   = 4'd0;
         end
         RELEASE: begin
            if (sample) begin
               if (row_high) begin
                  deb_nx = deb_cnt + 4'd1;
                  if (deb_cnt + 4'd1 == DEB_TARGET) begin
                     deb_nx       = 4'd0;
                     state_nx     = SCAN;
                     col_nx       = col_next;
                     release_done = 1'b1;
                  end
               end else begin
                  deb_nx = 4'd0;
               end
            end
         end
         default: state_nx = SCAN;
      endcase
   end

   // Key outputs are loaded on the edge that enters PRESSED, so key_valid is
   // visible in the PRESSED cycle, one cycle after the final debounce sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         run       <= 1'b0;
         dwell     <= '0;
         col_idx   <= '0;
         row_lat   <= '0;
         deb_cnt   <= '0;
         state     <= SCAN;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         run     <= 1'b1;
         dwell   <= (!run || dwell == DWELL_LAST) ? '0 : dwell + 1'b1;
         col_idx <= col_nx;
         row_lat <= row_nx;
         deb_cnt <= deb_nx;
         state   <= state_nx;
         overrun <= 1'b0;

         if (key_valid && key_ready) key_valid <= 1'b0;

         if (accept) begin
            key_held <= 1'b1;
            if (key_valid && !key_ready) begin
               overrun <= 1'b1;   // previous key still pending: drop the new one
            end else begin
               key_code  <= CODE_W'(row_nx) * CODE_W'(COLS) + CODE_W'(col_idx);
               key_valid <= 1'b1;
            end
         end

         if (release_done) key_held <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Self-checking bench for keypad_scanner (ROWS=4, COLS=4, SCAN_DIV=4,
// DEBOUNCE_CNT=3). A matrix model turns the set of pressed keys plus col_n into
// row_n. Expected key codes are queued when a key is pressed and popped when
// the DUT presents a new key.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int ROWS   = 4;
   localparam int COLS   = 4;
   localparam int CODE_W = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ROWS-1:0]   row_n;
   logic [COLS-1:0]   col_n;
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_ready = 1'b0;
   logic              key_held;
   logic              overrun;

   logic [ROWS*COLS-1:0] pressed = '0;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_q[$];

   keypad_scanner #(
      .ROWS        (ROWS),
      .COLS        (COLS),
      .SCAN_DIV    (4),
      .DEBOUNCE_CNT(3),
      .CODE_W      (CODE_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .row_n    (row_n),
      .col_n    (col_n),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .key_held (key_held),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row_n = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (pressed[r*COLS+c] && !col_n[c]) row_n[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) step();
   endtask

   // Called at a negedge. Checks outputs one cycle into reset, then releases
   // it so that the next step() lands on cycle 0.
   task automatic do_reset();
      rst       = 1'b1;
      key_ready = 1'b0;
      step();
      check("rst_col_n",     col_n,     4'b1111);
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_key_held",  key_held,  1'b0);
      check("rst_overrun",   overrun,   1'b0);
      check("rst_key_code",  key_code,  4'd0);
      step();
      rst = 1'b0;
      cyc = -1;
   endtask

   // Scoreboard monitor: just after each edge, a new key is on the port if
   // key_valid is high and was either low before or was just consumed.
   logic prev_valid = 1'b0;
   always @(posedge clk) begin
      #1;
      if (key_valid && (!prev_valid || key_ready)) begin
         check("sb_key_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) check("sb_key_code", key_code, exp_q.pop_front());
      end
      prev_valid = key_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_col;
      logic       saw_valid;
      int         ov_count;
      int         waited;

      @(negedge clk);

      // 1. Basic press of code 6 (row 1, col 2), no ready.
      pressed = '0;
      pressed[6] = 1'b1;
      exp_q.push_back(6);
      do_reset();
      for (int k = 0; k <= 20; k++) begin
         step();
         exp_col = (k < 4) ? 4'b1110 : (k < 8) ? 4'b1101 : 4'b1011;
         check("s1_col_n", col_n, exp_col);
         if (k == 19) check("s1_valid_before", key_valid, 1'b0);
      end
      check("s1_key_valid", key_valid, 1'b1);
      check("s1_key_code",  key_code,  4'd6);
      check("s1_key_held",  key_held,  1'b1);

      // 2. Consume once, release, resume scanning at col 3.
      step();                               // cycle 21
      key_ready = 1'b1;
      step();                               // cycle 22
      key_ready = 1'b0;
      check("s2_valid_cleared", key_valid, 1'b0);
      pressed = '0;
      run_to(35);
      check("s2_held_last", key_held, 1'b1);
      check("s2_col_frozen", col_n, 4'b1011);
      step();                               // cycle 36
      check("s2_held_drop", key_held, 1'b0);
      check("s2_col_next", col_n, 4'b0111);

      // 3. Bounce on row 0 / col 0 for a single sample.
      pressed = '0;
      pressed[0] = 1'b1;
      do_reset();
      saw_valid = 1'b0;
      for (int k = 0; k <= 40; k++) begin
         step();
         if (k == 3) pressed = '0;
         if (k == 4) check("s3_col_frozen", col_n, 4'b1110);
         if (k == 8) check("s3_col_advance", col_n, 4'b1101);
         if (k == 12) check("s3_col_scan", col_n, 4'b1011);
         if (key_valid) saw_valid = 1'b1;
      end
      check("s3_no_key", saw_valid, 1'b0);

      // 4. Overrun: code 6 unconsumed, then code 1 is pressed and dropped.
      pressed = '0;
      pressed[6] = 1'b1;
      exp_q.push_back(6);
      do_reset();
      run_to(21);
      pressed = '0;
      run_to(32);
      check("s4_col_after_release", col_n, 4'b0111);
      check("s4_held_cleared", key_held, 1'b0);
      pressed[1] = 1'b1;
      ov_count = overrun ? 1 : 0;
      waited = 0;
      while (!key_held && waited < 100) begin
         step();
         waited++;
         if (overrun) ov_count++;
      end
      check("s4_accept_cycle", cyc, 52);
      check("s4_overrun_pulse", overrun, 1'b1);
      check("s4_code_kept", key_code, 4'd6);
      check("s4_valid_kept", key_valid, 1'b1);
      check("s4_held_set", key_held, 1'b1);
      for (int k = 0; k < 10; k++) begin
         step();
         if (overrun) ov_count++;
      end
      check("s4_overrun_count", ov_count, 1);
      pressed = '0;

      // 5. Rows 1 and 3 in col 3 (row 1 wins), then code 9 accepted on the
      //    same edge as a handshake.
      pressed = '0;
      pressed[7]  = 1'b1;
      pressed[15] = 1'b1;
      exp_q.push_back(7);
      do_reset();
      run_to(24);
      check("s5_first_valid", key_valid, 1'b1);
      check("s5_first_code",  key_code,  4'd7);
      pressed = '0;
      pressed[9] = 1'b1;
      exp_q.push_back(9);
      run_to(51);
      check("s5_still_first", key_code, 4'd7);
      key_ready = 1'b1;
      step();                               // cycle 52
      key_ready = 1'b0;
      check("s5_valid_stays", key_valid, 1'b1);
      check("s5_new_code",    key_code,  4'd9);
      check("s5_no_overrun",  overrun,   1'b0);
      check("s5_held",        key_held,  1'b1);
      pressed = '0;

      // 6. Reset while debouncing code 0; scanning restarts at col 0.
      pressed = '0;
      pressed[0] = 1'b1;
      do_reset();
      run_to(5);
      check("s6_debounce_col", col_n, 4'b1110);
      pressed = '0;
      do_reset();
      step();
      check("s6_restart_col0", col_n, 4'b1110);
      run_to(4);
      check("s6_restart_col1", col_n, 4'b1101);
      check("s6_no_key", key_valid, 1'b0);

      step();
      check("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
